// File: rtl/feature_align_buf.sv
// -----------------------------------------------------------------------------
// feature_align_buf
//
// In-order alignment buffer between the flow tracker and the ALUs. Every
// meta-feature is queued together with its hash-hit flag. A miss can leave as
// soon as it reaches the head of the queue. A hit waits at the head until its
// history record has arrived from main_feature_mem. Each meta leaves as one
// merged record {meta, history record, hit} through a registered output stage.
// History records are paired with hits purely by arrival order; there is no
// tag check.
//
// Handshake: a record moves from o_* to the ALU in every cycle where
// o_v & i_alu_rdy is high at the rising clock edge. While o_v is high and
// i_alu_rdy is low, all o_* outputs hold their values. i_meta_v has no
// backpressure of its own: a meta presented while o_meta_rdy is low is
// dropped. i_cache_v cannot be backpressured at all.
//
// Ports
//   clk, rst_n    clock; asynchronous active-low reset (flushes everything)
//   i_meta        meta-feature from the tracker
//   i_hit         hash hit for this meta
//   i_meta_v      meta valid
//   o_meta_rdy    meta FIFO not full (start-of-cycle, no pop look-ahead)
//   i_cache_data  history record {max_sz,min_sz,max_arit,min_arit,vec}
//   i_cache_v     history record valid
//   o_meta        merged output: meta
//   o_cache_data  merged output: history record (0 for a miss)
//   o_hit         merged output: hit flag
//   o_v           merged output valid
//   i_alu_rdy     ALU accepts the merged output
//   o_level       meta FIFO occupancy, 0..DEPTH (output register excluded)
//   i_clr_err     clears both sticky error flags
//   o_ovf_err     sticky: a meta was dropped because the meta FIFO was full
//   o_orphan_err  sticky: a history record was dropped (cache FIFO full)
// -----------------------------------------------------------------------------
module feature_align_buf #(
    parameter int META_W  = 168,
    parameter int CACHE_W = 192,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [META_W-1:0]          i_meta,
    input  logic                       i_hit,
    input  logic                       i_meta_v,
    output logic                       o_meta_rdy,
    input  logic [CACHE_W-1:0]         i_cache_data,
    input  logic                       i_cache_v,
    output logic [META_W-1:0]          o_meta,
    output logic [CACHE_W-1:0]         o_cache_data,
    output logic                       o_hit,
    output logic                       o_v,
    input  logic                       i_alu_rdy,
    output logic [$clog2(DEPTH):0]     o_level,
    input  logic                       i_clr_err,
    output logic                       o_ovf_err,
    output logic                       o_orphan_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // -------------------------------------------------------------------------
    // Meta FIFO: entries are {hit, meta}
    // -------------------------------------------------------------------------
    logic [META_W:0]   meta_mem [DEPTH];
    logic [AW-1:0]     m_wr;
    logic [AW-1:0]     m_rd;
    logic [LW-1:0]     m_cnt;
    logic              m_full;
    logic              m_empty;
    logic              m_push;
    logic              m_pop;

    // -------------------------------------------------------------------------
    // Cache FIFO: history records waiting for their hit
    // -------------------------------------------------------------------------
    logic [CACHE_W-1:0] cache_mem [DEPTH];
    logic [AW-1:0]      c_wr;
    logic [AW-1:0]      c_rd;
    logic [LW-1:0]      c_cnt;
    logic               c_full;
    logic               c_empty;
    logic               c_push;
    logic               c_pop;

    // -------------------------------------------------------------------------
    // Merge control
    // -------------------------------------------------------------------------
    logic               head_hit;
    logic [META_W-1:0]  head_meta;
    logic               merge;
    logic               load;
    logic               ovf_set;
    logic               orph_set;

    assign m_full   = (m_cnt == LW'(DEPTH));
    assign m_empty  = (m_cnt == '0);
    assign c_full   = (c_cnt == LW'(DEPTH));
    assign c_empty  = (c_cnt == '0);

    assign head_hit  = meta_mem[m_rd][META_W];
    assign head_meta = meta_mem[m_rd][META_W-1:0];

    // The head can leave when it is a miss, or when its history record is
    // already sitting in the cache FIFO. Everything is start-of-cycle state,
    // so a record written this cycle is never merged in the same cycle.
    assign merge = !m_empty && (!head_hit || !c_empty);
    assign load  = merge && (!o_v || i_alu_rdy);

    assign m_push = i_meta_v && !m_full;
    assign m_pop  = load;
    assign c_push = i_cache_v && !c_full;
    assign c_pop  = load && head_hit;

    assign ovf_set  = i_meta_v && m_full;
    assign orph_set = i_cache_v && c_full;

    assign o_meta_rdy = !m_full;
    assign o_level    = m_cnt;

    // -------------------------------------------------------------------------
    // Storage (data only, no reset needed: validity lives in the counters)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (m_push) begin
            meta_mem[m_wr] <= {i_hit, i_meta};
        end
        if (c_push) begin
            cache_mem[c_wr] <= i_cache_data;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
    // naturally at AW bits.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wr  <= '0;
            m_rd  <= '0;
            m_cnt <= '0;
            c_wr  <= '0;
            c_rd  <= '0;
            c_cnt <= '0;
        end else begin
            if (m_push) begin
                m_wr <= m_wr + AW'(1);
            end
            if (m_pop) begin
                m_rd <= m_rd + AW'(1);
            end
            case ({m_push, m_pop})
                2'b10:   m_cnt <= m_cnt + LW'(1);
                2'b01:   m_cnt <= m_cnt - LW'(1);
                default: m_cnt <= m_cnt;
            endcase

            if (c_push) begin
                c_wr <= c_wr + AW'(1);
            end
            if (c_pop) begin
                c_rd <= c_rd + AW'(1);
            end
            case ({c_push, c_pop})
                2'b10:   c_cnt <= c_cnt + LW'(1);
                2'b01:   c_cnt <= c_cnt - LW'(1);
                default: c_cnt <= c_cnt;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output register. Loads a new merged record whenever it is empty or its
    // current record is being accepted; otherwise it holds.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_v          <= 1'b0;
            o_meta       <= '0;
            o_cache_data <= '0;
            o_hit        <= 1'b0;
        end else if (load) begin
            o_v          <= 1'b1;
            o_meta       <= head_meta;
            o_hit        <= head_hit;
            o_cache_data <= head_hit ? cache_mem[c_rd] : '0;
        end else if (i_alu_rdy) begin
            o_v          <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky error flags. A new error in the same cycle as i_clr_err wins.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_ovf_err    <= 1'b0;
            o_orphan_err <= 1'b0;
        end else begin
            o_ovf_err    <= ovf_set  || (o_ovf_err    && !i_clr_err);
            o_orphan_err <= orph_set || (o_orphan_err && !i_clr_err);
        end
    end

endmodule

// File: tb/tb_feature_align_buf.sv
// -----------------------------------------------------------------------------
// Bench for feature_align_buf. A queue-based reference model (meta queue,
// cache queue, output-valid bit, two flags) advances once per clock alongside
// the DUT; merged records it produces go into exp_q and are compared when the
// DUT hands them over. A cycle table and hand-written sequences cover the
// exact latency, backpressure, overflow, orphan and reset cases.
// -----------------------------------------------------------------------------
module tb_feature_align_buf;

    localparam int META_W  = 168;
    localparam int CACHE_W = 192;
    localparam int DEPTH   = 8;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int EW      = 1 + CACHE_W + META_W;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT signals
    logic [META_W-1:0]  d_meta = '0;
    logic               d_hit = 1'b0;
    logic               d_meta_v = 1'b0;
    logic [CACHE_W-1:0] d_cache = '0;
    logic               d_cache_v = 1'b0;
    logic               d_alu_rdy = 1'b0;
    logic               d_clr = 1'b0;

    logic               q_meta_rdy;
    logic [META_W-1:0]  q_meta;
    logic [CACHE_W-1:0] q_cache;
    logic               q_hit;
    logic               q_v;
    logic [LW-1:0]      q_level;
    logic               q_ovf;
    logic               q_orph;

    feature_align_buf #(
        .META_W (META_W),
        .CACHE_W(CACHE_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_meta      (d_meta),
        .i_hit       (d_hit),
        .i_meta_v    (d_meta_v),
        .o_meta_rdy  (q_meta_rdy),
        .i_cache_data(d_cache),
        .i_cache_v   (d_cache_v),
        .o_meta      (q_meta),
        .o_cache_data(q_cache),
        .o_hit       (q_hit),
        .o_v         (q_v),
        .i_alu_rdy   (d_alu_rdy),
        .o_level     (q_level),
        .i_clr_err   (d_clr),
        .o_ovf_err   (q_ovf),
        .o_orphan_err(q_orph)
    );

    // ---------------------------------------------------------------- counters
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- reference model
    typedef struct packed {
        logic              hit;
        logic [META_W-1:0] meta;
    } mrec_t;

    mrec_t              mq[$];
    logic [CACHE_W-1:0] cq[$];
    logic [EW-1:0]      exp_q[$];
    logic               m_ov;
    logic               m_ovf;
    logic               m_orph;

    task automatic model_reset();
        mq.delete();
        cq.delete();
        exp_q.delete();
        m_ov   = 1'b0;
        m_ovf  = 1'b0;
        m_orph = 1'b0;
    endtask

    // One clock of the model using the inputs currently driven.
    task automatic model_step();
        bit            m_full;
        bit            c_full;
        bit            can_go;
        logic [EW-1:0] e;
        m_full = (mq.size() == DEPTH);
        c_full = (cq.size() == DEPTH);
        can_go = (mq.size() > 0) && (!mq[0].hit || cq.size() > 0);
        if (can_go && (!m_ov || d_alu_rdy)) begin
            e = {mq[0].hit, (mq[0].hit ? cq[0] : {CACHE_W{1'b0}}), mq[0].meta};
            exp_q.push_back(e);
            if (mq[0].hit) void'(cq.pop_front());
            void'(mq.pop_front());
            m_ov = 1'b1;
        end else if (d_alu_rdy) begin
            m_ov = 1'b0;
        end
        if (d_meta_v && !m_full) mq.push_back({d_hit, d_meta});
        if (d_cache_v && !c_full) cq.push_back(d_cache);
        m_ovf  = (d_meta_v && m_full)   ? 1'b1 : (d_clr ? 1'b0 : m_ovf);
        m_orph = (d_cache_v && c_full)  ? 1'b1 : (d_clr ? 1'b0 : m_orph);
    endtask

    task automatic check_model();
        chk("m_v", 384'(q_v), 384'(m_ov));
        chk("m_level", 384'(q_level), 384'(mq.size()));
        chk("m_rdy", 384'(q_meta_rdy), 384'(mq.size() != DEPTH));
        chk("m_ovf", 384'(q_ovf), 384'(m_ovf));
        chk("m_orph", 384'(q_orph), 384'(m_orph));
    endtask

    // ---------------------------------------------------------------- driver tasks
    // Scoreboard pop on handshake, model step, clock edge, then state check.
    task automatic cycle();
        logic [EW-1:0] e;
        if (q_v && d_alu_rdy) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 384'(1), 384'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb_rec", 384'({q_hit, q_cache, q_meta}), 384'(e));
            end
        end
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        d_meta_v  = 1'b0;
        d_cache_v = 1'b0;
        d_clr     = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        #2;
        chk("rst_v", 384'(q_v), 384'(0));
        chk("rst_level", 384'(q_level), 384'(0));
        chk("rst_rdy", 384'(q_meta_rdy), 384'(1));
        chk("rst_ovf", 384'(q_ovf), 384'(0));
        chk("rst_orph", 384'(q_orph), 384'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_meta(input logic [META_W-1:0] m, input logic h);
        d_meta_v = 1'b1;
        d_meta   = m;
        d_hit    = h;
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------------------------------------------------------- cycle table
    typedef struct {
        logic       mv;
        logic       hit;
        logic [7:0] meta;
        logic       cv;
        logic [7:0] cache;
        logic       rdy;
        logic       ev;
        logic [7:0] emeta;
        logic [7:0] ecache;
        logic       ehit;
        int         elevel;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [255:0] r;

        // Row inputs apply during one cycle; expectations are the outputs in
        // the following cycle.
        // Miss A1 accepted at row 0 -> visible two cycles after acceptance.
        tbl[0] = '{1'b1, 1'b0, 8'hA1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, 8'h00, 1'b0, 0};
        tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 0};
        // Hit B2 at t=row3, miss D4 at t+1, cache C3 at t+3 -> B at t+5, D at t+6.
        tbl[3] = '{1'b1, 1'b1, 8'hB2, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1};
        tbl[4] = '{1'b1, 1'b0, 8'hD4, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 2};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 2};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hC3, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 2};
        tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hB2, 8'hC3, 1'b1, 1};
        tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hD4, 8'h00, 1'b0, 0};
        tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 0};

        model_reset();
        #1;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            d_meta_v  = tbl[i].mv;
            d_hit     = tbl[i].hit;
            d_meta    = META_W'(tbl[i].meta);
            d_cache_v = tbl[i].cv;
            d_cache   = CACHE_W'(tbl[i].cache);
            d_alu_rdy = tbl[i].rdy;
            cycle();
            chk("tbl_v", 384'(q_v), 384'(tbl[i].ev));
            chk("tbl_level", 384'(q_level), 384'(tbl[i].elevel));
            if (tbl[i].ev) begin
                chk("tbl_meta", 384'(q_meta), 384'(tbl[i].emeta));
                chk("tbl_cache", 384'(q_cache), 384'(tbl[i].ecache));
                chk("tbl_hit", 384'(q_hit), 384'(tbl[i].ehit));
            end
        end
        d_meta_v  = 1'b0;
        d_cache_v = 1'b0;

        // ---------------- backpressure: 8 misses with the ALU stalled
        do_reset();
        d_alu_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_meta(META_W'(8'h30 + i), 1'b0);
            cycle();
        end
        d_meta_v = 1'b0;
        chk("bp_level", 384'(q_level), 384'(7));
        chk("bp_v", 384'(q_v), 384'(1));
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("bp_stable", 384'(q_meta), 384'(8'h30));
        end
        d_alu_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("bp_drain_v", 384'(q_v), 384'(1));
            chk("bp_drain_meta", 384'(q_meta), 384'(8'h30 + i));
            cycle();
        end
        chk("bp_done_v", 384'(q_v), 384'(0));

        // ---------------- overflow: 10 metas into DEPTH 8 + output register
        do_reset();
        d_alu_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("ovf_rdy", 384'(q_meta_rdy), 384'(i < 9));
            push_meta(META_W'(8'h40 + i), 1'b0);
            cycle();
            if (i == 8) chk("ovf_pre", 384'(q_ovf), 384'(0));
        end
        d_meta_v = 1'b0;
        chk("ovf_flag", 384'(q_ovf), 384'(1));
        chk("ovf_level", 384'(q_level), 384'(8));
        d_clr = 1'b1;
        cycle();
        d_clr = 1'b0;
        chk("ovf_clr", 384'(q_ovf), 384'(0));
        d_alu_rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("ovf_drain_meta", 384'(q_meta), 384'(8'h40 + i));
            cycle();
        end
        chk("ovf_done_v", 384'(q_v), 384'(0));

        // ---------------- orphan: 9 history records with no hit pending
        do_reset();
        for (int i = 0; i < 9; i++) begin
            d_cache_v = 1'b1;
            d_cache   = CACHE_W'(8'h50 + i);
            cycle();
            if (i == 7) chk("orph_pre", 384'(q_orph), 384'(0));
        end
        d_cache_v = 1'b0;
        chk("orph_flag", 384'(q_orph), 384'(1));
        chk("orph_no_out", 384'(q_v), 384'(0));
        d_clr = 1'b1;
        cycle();
        d_clr = 1'b0;
        chk("orph_clr", 384'(q_orph), 384'(0));
        // Error in the same cycle as clear: the error wins.
        d_cache_v = 1'b1;
        d_clr     = 1'b1;
        cycle();
        d_cache_v = 1'b0;
        d_clr     = 1'b0;
        chk("orph_prio", 384'(q_orph), 384'(1));

        // ---------------- reset mid-flight (flag is set going in)
        do_reset();
        d_alu_rdy = 1'b1;
        push_meta(META_W'(8'h61), 1'b1);
        cycle();
        push_meta(META_W'(8'h62), 1'b1);
        cycle();
        push_meta(META_W'(8'h63), 1'b1);
        d_cache_v = 1'b1;
        d_cache   = CACHE_W'(8'hC6);
        cycle();
        d_meta_v  = 1'b0;
        d_cache_v = 1'b0;
        chk("mid_level", 384'(q_level), 384'(3));
        do_reset();
        push_meta(META_W'(8'h66), 1'b0);
        cycle();
        d_meta_v = 1'b0;
        chk("mid_miss_early", 384'(q_v), 384'(0));
        cycle();
        chk("mid_miss_v", 384'(q_v), 384'(1));
        chk("mid_miss_meta", 384'(q_meta), 384'(8'h66));
        chk("mid_miss_cache", 384'(q_cache), 384'(0));
        cycle();
        push_meta(META_W'(8'h77), 1'b1);
        cycle();
        d_meta_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("mid_hit_wait", 384'(q_v), 384'(0));
        end
        d_cache_v = 1'b1;
        d_cache   = CACHE_W'(8'hC7);
        cycle();
        d_cache_v = 1'b0;
        cycle();
        chk("mid_hit_v", 384'(q_v), 384'(1));
        chk("mid_hit_rec", 384'({q_hit, q_cache, q_meta}),
            384'({1'b1, CACHE_W'(8'hC7), META_W'(8'h77)}));
        cycle();

        // ---------------- randomized traffic against the model
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            for (int n = 0; n < 1000; n++) begin
                r = rnd256();
                d_meta_v  = ($urandom_range(0, 99) < 60);
                d_hit     = $urandom_range(0, 1);
                d_meta    = r[META_W-1:0];
                r = rnd256();
                d_cache_v = ($urandom_range(0, 99) < 35);
                d_cache   = r[CACHE_W-1:0];
                d_alu_rdy = (ph == 0) ? ($urandom_range(0, 99) < 75)
                                      : ($urandom_range(0, 99) < 30);
                d_clr     = ($urandom_range(0, 99) < 3);
                cycle();
                if (n == 500) do_reset();
            end
            d_meta_v  = 1'b0;
            d_cache_v = 1'b0;
            d_clr     = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
